// File: rtl/score_digit_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// score_digit_sequencer_pkg
// Shared constants and types for the score readout. Holds the sequencer state
// encoding, the displayable range, the glyph-strip geometry and the per-nibble
// BCD correction helper. The score image block uses the same geometry.
// ---------------------------------------------------------------------------
package score_digit_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } seq_state_t;

    localparam int SCORE_BITS      = 10;
    localparam int MAX_SCORE       = 999;
    localparam int NUM_GLYPHS      = 10;
    localparam int NUM_STRIP_WIDTH = 342;
    localparam int NUM_WIDTH       = NUM_STRIP_WIDTH / NUM_GLYPHS;   // 34 pixels per glyph
    localparam int OFS_BITS        = 16;
    localparam int BCD_DIGITS      = 3;
    localparam int BCD_BITS        = 4 * BCD_DIGITS;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // once shifted, so bias it by 3 beforehand.
    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/score_digit_sequencer_if.sv
// ---------------------------------------------------------------------------
// score_digit_sequencer_if
// Bundles the score sequencer's request and display signals.
//   frame_start, score          : game side -> sequencer
//   hundreds, tens, ones        : BCD digits
//   num_digits                  : visible digit count, 1..3
//   *_ofs                       : digit * glyph width, image offsets
//   busy, update                : conversion status / new-values pulse
// master: drives the request (game / testbench); slave: the sequencer.
// ---------------------------------------------------------------------------
interface score_digit_sequencer_if #(
    parameter int OFS_BITS = 16
);
    logic                frame_start;
    logic [31:0]         score;
    logic [3:0]          hundreds;
    logic [3:0]          tens;
    logic [3:0]          ones;
    logic [1:0]          num_digits;
    logic [OFS_BITS-1:0] hundreds_ofs;
    logic [OFS_BITS-1:0] tens_ofs;
    logic [OFS_BITS-1:0] ones_ofs;
    logic                busy;
    logic                update;

    modport master (
        output frame_start, score,
        input  hundreds, tens, ones, num_digits,
        input  hundreds_ofs, tens_ofs, ones_ofs, busy, update
    );

    modport slave (
        input  frame_start, score,
        output hundreds, tens, ones, num_digits,
        output hundreds_ofs, tens_ofs, ones_ofs, busy, update
    );
endinterface

// File: rtl/score_digit_sequencer_bcd_add3_stage.sv
// ---------------------------------------------------------------------------
// bcd_add3_stage
// Combinational double-dabble correction over a 3-digit BCD accumulator:
// every nibble >= 5 gets +3, others pass through.
//   bcd_in  [11:0] : accumulator before the shift
//   bcd_out [11:0] : corrected accumulator, ready to shift left
// ---------------------------------------------------------------------------
module bcd_add3_stage
    import score_digit_sequencer_pkg::*;
(
    input  logic [BCD_BITS-1:0] bcd_in,
    output logic [BCD_BITS-1:0] bcd_out
);

    // Per-nibble correction, nibbles are independent of each other.
    always_comb begin
        bcd_out = {BCD_BITS{1'b0}};
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_out[4*i +: 4] = add3_nibble(bcd_in[4*i +: 4]);
        end
    end

endmodule

// File: rtl/score_digit_sequencer.sv
// ---------------------------------------------------------------------------
// score_digit_sequencer
// Once per frame, samples the score, saturates it to MAX_SCORE and converts it
// to BCD one bit per cycle. Digits, glyph offsets and the visible-digit count
// are only rewritten on the commit edge, so the pixel path sees whole values.
//   clk    : system clock
//   reset  : synchronous, active-high, dominates everything
//   bus    : slave side of score_digit_sequencer_if (request + display)
// Timing: update pulses SCORE_BITS+1 cycles after the edge that accepted
// frame_start; busy covers the cycles in between. A frame_start arriving
// while busy is remembered (one deep) and starts right after commit.
// ---------------------------------------------------------------------------
module score_digit_sequencer
    import score_digit_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    score_digit_sequencer_if.slave bus
);

    localparam int CNT_BITS = $clog2(SCORE_BITS + 1);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(SCORE_BITS - 1);

    seq_state_t              state_r, state_s;
    logic                    pending_r, pending_s;
    logic                    load_s, shift_s, commit_s;
    logic [SCORE_BITS-1:0]   sat_r, sat_s;
    logic [BCD_BITS-1:0]     bcd_r, bcd_adj_s;
    logic [CNT_BITS-1:0]     cnt_r;

    logic [3:0]              hundreds_r, tens_r, ones_r;
    logic [1:0]              num_digits_r;
    logic [OFS_BITS-1:0]     hundreds_ofs_r, tens_ofs_r, ones_ofs_r;
    logic                    busy_r, update_r;

    bcd_add3_stage u_add3 (
        .bcd_in  (bcd_r),
        .bcd_out (bcd_adj_s)
    );

    // Saturate the incoming score to the displayable range.
    always_comb begin
        if (bus.score > 32'(MAX_SCORE)) begin
            sat_s = SCORE_BITS'(MAX_SCORE);
        end else begin
            sat_s = bus.score[SCORE_BITS-1:0];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.frame_start) begin
                    state_s = CONVERT;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVERT: begin
                shift_s = 1'b1;
                if (bus.frame_start) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (cnt_r == LAST_BIT) begin
                    state_s = COMMIT;
                end else begin
                    state_s = CONVERT;
                end
            end
            COMMIT: begin
                commit_s  = 1'b1;
                pending_s = 1'b0;
                // A request landing on the commit cycle is served straight away
                // rather than being lost between pending clear and IDLE.
                if (pending_r || bus.frame_start) begin
                    state_s = CONVERT;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s   = IDLE;
                pending_s = 1'b0;
            end
        endcase
    end

    // State and pending-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
        end
    end

    // Conversion datapath: load, then correct-and-shift {bcd,sat} once per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= {SCORE_BITS{1'b0}};
            bcd_r <= {BCD_BITS{1'b0}};
            cnt_r <= {CNT_BITS{1'b0}};
        end else if (load_s) begin
            sat_r <= sat_s;
            bcd_r <= {BCD_BITS{1'b0}};
            cnt_r <= {CNT_BITS{1'b0}};
        end else if (shift_s) begin
            {bcd_r, sat_r} <= {bcd_adj_s[BCD_BITS-2:0], sat_r, 1'b0};
            cnt_r          <= cnt_r + CNT_BITS'(1);
        end else begin
            sat_r <= sat_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
        end
    end

    // Display registers: rewritten only on the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hundreds_r     <= 4'd0;
            tens_r         <= 4'd0;
            ones_r         <= 4'd0;
            num_digits_r   <= 2'd1;
            hundreds_ofs_r <= {OFS_BITS{1'b0}};
            tens_ofs_r     <= {OFS_BITS{1'b0}};
            ones_ofs_r     <= {OFS_BITS{1'b0}};
            update_r       <= 1'b0;
        end else if (commit_s) begin
            hundreds_r     <= bcd_r[11:8];
            tens_r         <= bcd_r[7:4];
            ones_r         <= bcd_r[3:0];
            if (bcd_r[11:8] != 4'd0) begin
                num_digits_r <= 2'd3;
            end else if (bcd_r[7:4] != 4'd0) begin
                num_digits_r <= 2'd2;
            end else begin
                num_digits_r <= 2'd1;
            end
            hundreds_ofs_r <= OFS_BITS'(bcd_r[11:8]) * OFS_BITS'(NUM_WIDTH);
            tens_ofs_r     <= OFS_BITS'(bcd_r[7:4])  * OFS_BITS'(NUM_WIDTH);
            ones_ofs_r     <= OFS_BITS'(bcd_r[3:0])  * OFS_BITS'(NUM_WIDTH);
            update_r       <= 1'b1;
        end else begin
            update_r       <= 1'b0;
        end
    end

    // busy follows the state being entered, so it drops right after commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
        end
    end

    assign bus.hundreds     = hundreds_r;
    assign bus.tens         = tens_r;
    assign bus.ones         = ones_r;
    assign bus.num_digits   = num_digits_r;
    assign bus.hundreds_ofs = hundreds_ofs_r;
    assign bus.tens_ofs     = tens_ofs_r;
    assign bus.ones_ofs     = ones_ofs_r;
    assign bus.busy         = busy_r;
    assign bus.update       = update_r;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_score_digit_sequencer
// Directed scenarios followed by random frame pulses, scores and resets. A
// transaction-level model pushes the expected display record (with its due
// cycle) when a conversion is accepted; a monitor pops and compares whenever
// the sequencer pulses update, and checks busy and held outputs every cycle.
// ---------------------------------------------------------------------------
module tb_score_digit_sequencer;

    typedef struct packed {
        logic [3:0]  hund;
        logic [3:0]  tens;
        logic [3:0]  ones;
        logic [1:0]  nd;
        logic [15:0] hofs;
        logic [15:0] tofs;
        logic [15:0] oofs;
    } disp_t;

    typedef struct {
        int    due;
        disp_t d;
    } exp_t;

    localparam disp_t RESET_DISP = '{hund: 4'd0, tens: 4'd0, ones: 4'd0, nd: 2'd1,
                                     hofs: 16'd0, tofs: 16'd0, oofs: 16'd0};
    localparam int LATENCY = 11;

    logic clk;
    logic reset;

    score_digit_sequencer_if #(.OFS_BITS(16)) bus ();

    score_digit_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  q[$];
    int    cyc        = 0;
    int    next_free  = 0;
    logic  pending    = 1'b0;
    logic  busy_exp   = 1'b0;
    logic  rst_edge   = 1'b0;
    disp_t disp_exp   = RESET_DISP;
    int    checks     = 0;
    int    fails      = 0;
    logic  final_chk  = 1'b0;
    logic  final_done = 1'b0;

    // Expected display straight from the decimal value.
    function automatic disp_t ref_disp(input logic [31:0] sc);
        int unsigned v;
        disp_t d;
        v = (sc > 32'd999) ? 999 : int'(sc);
        d.hund = 4'(v / 100);
        d.tens = 4'((v / 10) % 10);
        d.ones = 4'(v % 10);
        d.nd   = (v >= 100) ? 2'd3 : ((v >= 10) ? 2'd2 : 2'd1);
        d.hofs = 16'(int'(d.hund) * 34);
        d.tofs = 16'(int'(d.tens) * 34);
        d.oofs = 16'(int'(d.ones) * 34);
        return d;
    endfunction

    // Reference model: a conversion occupies LATENCY cycles; requests during it
    // merge into one queued request served the moment it finishes.
    always @(posedge clk) begin
        int t;
        t = cyc + 1;
        cyc      <= t;
        rst_edge <= reset;
        if (reset) begin
            pending   <= 1'b0;
            next_free <= 0;
            busy_exp  <= 1'b0;
        end else if (t >= next_free && (bus.frame_start || pending)) begin
            q.push_back('{due: t + LATENCY, d: ref_disp(bus.score)});
            next_free <= t + LATENCY;
            pending   <= 1'b0;
            busy_exp  <= 1'b1;
        end else begin
            if (t < next_free && bus.frame_start) pending <= 1'b1;
            busy_exp <= (t < next_free);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        disp_t act;
        act = '{hund: bus.hundreds, tens: bus.tens, ones: bus.ones, nd: bus.num_digits,
                hofs: bus.hundreds_ofs, tofs: bus.tens_ofs, oofs: bus.ones_ofs};
        if (rst_edge) begin
            q.delete();
            disp_exp = RESET_DISP;
        end
        while (q.size() > 0 && q[0].due < cyc) begin
            checks++; fails++;
            $display("FAIL missed_update: no update by cycle %0d, required at cycle %0d", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (bus.update) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_update: update=1 at cycle %0d, required 0", cyc);
            end else if (q[0].due != cyc) begin
                fails++;
                $display("FAIL update_timing: update at cycle %0d, required at cycle %0d", cyc, q[0].due);
            end else begin
                if (act !== q[0].d) begin
                    fails++;
                    $display("FAIL update_values: got %h, required %h at cycle %0d", act, q[0].d, cyc);
                end
                disp_exp = q[0].d;
                void'(q.pop_front());
            end
        end
        checks++;
        if (bus.busy !== busy_exp) begin
            fails++;
            $display("FAIL busy: got %b, required %b at cycle %0d", bus.busy, busy_exp, cyc);
        end
        checks++;
        if (act !== disp_exp) begin
            fails++;
            $display("FAIL held_display: got %h, required %h at cycle %0d", act, disp_exp, cyc);
        end
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (q.size() != 0) begin
                fails++;
                $display("FAIL drain: %0d updates outstanding, required 0", q.size());
            end
        end
    end

    task automatic step(input logic fs, input logic [31:0] sc, input logic rs);
        @(negedge clk);
        bus.frame_start = fs;
        bus.score       = sc;
        reset           = rs;
    endtask

    task automatic convert_one(input logic [31:0] sc);
        step(1'b1, sc, 1'b0);
        repeat (LATENCY + 3) step(1'b0, sc, 1'b0);
    endtask

    initial begin
        logic [31:0] sc;
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.score       = 32'd57;
        // reset held, score=57
        repeat (3) step(1'b0, 32'd57, 1'b1);
        // single conversions, saturation
        convert_one(32'd0);
        convert_one(32'd907);
        convert_one(32'd40);
        convert_one(32'd1234);
        convert_one(32'hFFFF_FFFF);
        convert_one(32'd999);
        convert_one(32'd1000);
        // pending request with score change mid-conversion
        step(1'b1, 32'd12, 1'b0);
        step(1'b0, 32'd12, 1'b0);
        step(1'b0, 32'd12, 1'b0);
        step(1'b0, 32'd345, 1'b0);
        step(1'b0, 32'd345, 1'b0);
        step(1'b1, 32'd345, 1'b0);
        step(1'b0, 32'd345, 1'b0);
        step(1'b1, 32'd345, 1'b0);
        repeat (20) step(1'b0, 32'd345, 1'b0);
        // reset aborts a conversion
        step(1'b1, 32'd500, 1'b0);
        repeat (5) step(1'b0, 32'd500, 1'b0);
        step(1'b0, 32'd500, 1'b1);
        repeat (14) step(1'b0, 32'd500, 1'b0);
        convert_one(32'd88);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       sc = 32'($urandom_range(0, 99));
                1:       sc = 32'($urandom_range(0, 999));
                2:       sc = 32'($urandom_range(1000, 70000));
                default: sc = $urandom;
            endcase
            step($urandom_range(0, 7) == 0, sc, $urandom_range(0, 299) == 0);
        end
        repeat (30) step(1'b0, 32'd0, 1'b0);
        final_chk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
